// File: rtl/regs_wb_arbiter_if.sv
// ============================================================================
// Module   : regs_wb_arbiter_if
// Purpose  : Bundles the writeback, issue, scoreboard and regs-port signals of
//            regs_wb_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface regs_wb_arbiter_if #(
    parameter int unsigned AW   = 5,
    parameter int unsigned XLEN = 32
);
    logic            alu_valid;
    logic [AW-1:0]   alu_rdadr;
    logic [XLEN-1:0] alu_rd;
    logic            alu_ready;
    logic            lsu_valid;
    logic [AW-1:0]   lsu_rdadr;
    logic [XLEN-1:0] lsu_rd;
    logic            lsu_ready;
    logic            iss_valid;
    logic [AW-1:0]   iss_rdadr;
    logic            iss_ready;
    logic [AW-1:0]   rs1adr;
    logic [AW-1:0]   rs2adr;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            regwrite;
    logic [AW-1:0]   rdadr;
    logic [XLEN-1:0] rd;
    logic            rs1_fwd_valid;
    logic [XLEN-1:0] rs1_fwd_data;
    logic            rs2_fwd_valid;
    logic [XLEN-1:0] rs2_fwd_data;

    modport master (
        output alu_valid, alu_rdadr, alu_rd, lsu_valid, lsu_rdadr, lsu_rd,
        output iss_valid, iss_rdadr, rs1adr, rs2adr,
        input  alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
        input  regwrite, rdadr, rd,
        input  rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
    );

    modport slave (
        input  alu_valid, alu_rdadr, alu_rd, lsu_valid, lsu_rdadr, lsu_rd,
        input  iss_valid, iss_rdadr, rs1adr, rs2adr,
        output alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
        output regwrite, rdadr, rd,
        output rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
    );
endinterface

`default_nettype wire

// File: rtl/regs_wb_arbiter.sv
// ============================================================================
// Module   : regs_wb_arbiter
// Purpose  : Round-robin ALU/LSU writeback arbiter for the regs write port plus
//            a per-register busy scoreboard. Optional macro: WB_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regs_wb_arbiter #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned XLEN  = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    regs_wb_arbiter_if.slave  bus
);
    localparam int unsigned AW        = $clog2(NREGS);
    localparam logic        c_SRC_ALU = 1'b0;
    localparam logic        c_SRC_LSU = 1'b1;

    logic [NREGS-1:0] busy_q, busy_d;
    logic             last_grant_q, last_grant_d;
    logic             regwrite_q, regwrite_d;
    logic [AW-1:0]    rdadr_q, rdadr_d;
    logic [XLEN-1:0]  rd_q, rd_d;

    logic w_grant_alu;
    logic w_grant_lsu;
    logic w_iss_ready;
    logic w_iss_fire;

    // On a tie the source that did not win last time gets the port.
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_lsu = 1'b0;
        if (bus.alu_valid && bus.lsu_valid) begin
            w_grant_alu = (last_grant_q == c_SRC_LSU);
            w_grant_lsu = (last_grant_q == c_SRC_ALU);
        end else begin
            w_grant_alu = bus.alu_valid;
            w_grant_lsu = bus.lsu_valid;
        end
    end

    assign w_iss_ready = !busy_q[bus.iss_rdadr] || (bus.iss_rdadr == '0);
    assign w_iss_fire  = bus.iss_valid && w_iss_ready && (bus.iss_rdadr != '0);

    assign bus.alu_ready = w_grant_alu;
    assign bus.lsu_ready = w_grant_lsu;
    assign bus.iss_ready = w_iss_ready;
    assign bus.regwrite  = regwrite_q;
    assign bus.rdadr     = rdadr_q;
    assign bus.rd        = rd_q;

    always_comb begin
        last_grant_d = last_grant_q;
        regwrite_d   = 1'b0;
        rdadr_d      = rdadr_q;
        rd_d         = rd_q;
        busy_d       = busy_q;

        // x0 requests are accepted but never reach the register file.
        if (w_grant_alu) begin
            last_grant_d = c_SRC_ALU;
            regwrite_d   = (bus.alu_rdadr != '0);
            rdadr_d      = bus.alu_rdadr;
            rd_d         = bus.alu_rd;
        end else if (w_grant_lsu) begin
            last_grant_d = c_SRC_LSU;
            regwrite_d   = (bus.lsu_rdadr != '0);
            rdadr_d      = bus.lsu_rdadr;
            rd_d         = bus.lsu_rd;
        end

        // Issue is applied after commit so a same-edge set overrides the clear.
        if (regwrite_q) begin
            busy_d[rdadr_q] = 1'b0;
        end
        if (w_iss_fire) begin
            busy_d[bus.iss_rdadr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q       <= '0;
            last_grant_q <= c_SRC_LSU;
            regwrite_q   <= 1'b0;
            rdadr_q      <= '0;
            rd_q         <= '0;
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            regwrite_q   <= regwrite_d;
            rdadr_q      <= rdadr_d;
            rd_q         <= rd_d;
        end
    end

`ifdef WB_BYPASS_EN
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit         = regwrite_q && (rdadr_q != '0) && (rdadr_q == bus.rs1adr);
    assign w_rs2_hit         = regwrite_q && (rdadr_q != '0) && (rdadr_q == bus.rs2adr);
    assign bus.rs1_fwd_valid = w_rs1_hit;
    assign bus.rs2_fwd_valid = w_rs2_hit;
    assign bus.rs1_fwd_data  = w_rs1_hit ? rd_q : '0;
    assign bus.rs2_fwd_data  = w_rs2_hit ? rd_q : '0;
    assign bus.rs1_busy      = busy_q[bus.rs1adr] && !w_rs1_hit;
    assign bus.rs2_busy      = busy_q[bus.rs2adr] && !w_rs2_hit;
`else
    assign bus.rs1_fwd_valid = 1'b0;
    assign bus.rs2_fwd_valid = 1'b0;
    assign bus.rs1_fwd_data  = '0;
    assign bus.rs2_fwd_data  = '0;
    assign bus.rs1_busy      = busy_q[bus.rs1adr];
    assign bus.rs2_busy      = busy_q[bus.rs2adr];
`endif

endmodule

`default_nettype wire

// File: tb/tb_regs_wb_arbiter.sv
// ============================================================================
// Module   : tb_regs_wb_arbiter
// Purpose  : Self-checking bench for regs_wb_arbiter with a behavioural model
//            and a small register-file stand-in fed by the regs write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regs_wb_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    regs_wb_arbiter_if #(.AW(5), .XLEN(32)) bus ();

    regs_wb_arbiter #(.NREGS(32), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Stand-in for the real register file, written only through the DUT port.
    logic [31:0] tb_regs [32] = '{default: 32'h0};
    always @(posedge clk) if (bus.regwrite) tb_regs[bus.rdadr] <= bus.rd;

    // Behavioural model state
    bit          m_busy [32];
    bit          m_prefer_alu;
    bit          m_pend;
    logic [4:0]  m_pend_adr;
    logic [31:0] m_pend_data;
    logic [4:0]  m_out_adr;
    logic [31:0] m_out_data;
    logic [31:0] m_regs [32] = '{default: 32'h0};

    bit          e_alu_ready, e_lsu_ready, e_iss_ready, e_rs1_busy, e_rs2_busy;
    bit          e_f1v, e_f2v;
    logic [31:0] e_f1d, e_f2d;

    function automatic void model_eval();
        bit a, l, h1, h2;
        a = bus.alu_valid;
        l = bus.lsu_valid;
        e_alu_ready = a && (!l || m_prefer_alu);
        e_lsu_ready = l && (!a || !m_prefer_alu);
        e_iss_ready = (bus.iss_rdadr == 5'd0) || !m_busy[bus.iss_rdadr];
        e_rs1_busy  = m_busy[bus.rs1adr];
        e_rs2_busy  = m_busy[bus.rs2adr];
`ifdef WB_BYPASS_EN
        h1 = m_pend && (m_pend_adr == bus.rs1adr);
        h2 = m_pend && (m_pend_adr == bus.rs2adr);
`else
        h1 = 1'b0;
        h2 = 1'b0;
`endif
        e_f1v = h1;
        e_f2v = h2;
        e_f1d = h1 ? m_pend_data : 32'h0;
        e_f2d = h2 ? m_pend_data : 32'h0;
        if (h1) e_rs1_busy = 1'b0;
        if (h2) e_rs2_busy = 1'b0;
    endfunction

    function automatic void model_clock(input bit rst);
        if (m_pend) m_regs[m_pend_adr] = m_pend_data;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_pend       = 1'b0;
            m_out_adr    = 5'd0;
            m_out_data   = 32'h0;
            m_prefer_alu = 1'b1;
            return;
        end
        if (m_pend) m_busy[m_pend_adr] = 1'b0;
        if (bus.iss_valid && e_iss_ready && bus.iss_rdadr != 5'd0) m_busy[bus.iss_rdadr] = 1'b1;
        m_pend = 1'b0;
        if (e_alu_ready) begin
            m_out_adr    = bus.alu_rdadr;
            m_out_data   = bus.alu_rd;
            m_pend       = (bus.alu_rdadr != 5'd0);
            m_prefer_alu = 1'b0;
        end else if (e_lsu_ready) begin
            m_out_adr    = bus.lsu_rdadr;
            m_out_data   = bus.lsu_rd;
            m_pend       = (bus.lsu_rdadr != 5'd0);
            m_prefer_alu = 1'b1;
        end
        m_pend_adr  = m_out_adr;
        m_pend_data = m_out_data;
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_clock(reset);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rdadr = 5'd0; bus.alu_rd = 32'h0;
        bus.lsu_valid = 1'b0; bus.lsu_rdadr = 5'd0; bus.lsu_rd = 32'h0;
        bus.iss_valid = 1'b0; bus.iss_rdadr = 5'd0;
        bus.rs1adr    = 5'd0; bus.rs2adr    = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        #1;
        n_cmp++; if (bus.regwrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %0h want 0", bus.regwrite); end
        n_cmp++; if (bus.rdadr !== 5'd0) begin n_err++; $display("FAIL reset_rdadr: got %0h want 0", bus.rdadr); end
        n_cmp++; if (bus.rd !== 32'h0) begin n_err++; $display("FAIL reset_rd: got %0h want 0", bus.rd); end
        reset = 1'b0;
        bus.rs1adr = 5'($urandom_range(1, 31));
        bus.rs2adr = 5'($urandom_range(1, 31));
        bus.iss_rdadr = 5'($urandom_range(1, 31));
        #1;
        n_cmp++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b%0b want 00", bus.rs1_busy, bus.rs2_busy); end
        n_cmp++; if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL reset_iss_ready: got %0h want 1", bus.iss_ready); end
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        bus.iss_valid = 1'b1; bus.iss_rdadr = 5'd5;
        #1;
        n_cmp++; if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL basic_iss_ready: got %0h want 1", bus.iss_ready); end
        tick();
        bus.iss_valid = 1'b0; bus.rs1adr = 5'd5;
        #1;
        n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_set: got %0h want 1", bus.rs1_busy); end
        bus.alu_valid = 1'b1; bus.alu_rdadr = 5'd5; bus.alu_rd = 32'hABCD1234;
        #1;
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL basic_alu_ready: got %0h want 1", bus.alu_ready); end
        tick();
        bus.alu_valid = 1'b0;
        #1;
        n_cmp++; if (bus.regwrite !== 1'b1 || bus.rdadr !== 5'd5 || bus.rd !== 32'hABCD1234) begin n_err++;
            $display("FAIL basic_write: got %0h/%0h/%h want 1/5/abcd1234", bus.regwrite, bus.rdadr, bus.rd); end
        tick();
        #1;
        n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_clear: got %0h want 0", bus.rs1_busy); end
        n_cmp++; if (tb_regs[5] !== 32'hABCD1234) begin n_err++; $display("FAIL basic_regs_x5: got %h want abcd1234", tb_regs[5]); end
    endtask

    task automatic test_arbitration();
        logic [31:0] x1, x2;
        bit          want_alu;
        x1 = 32'h0; x2 = 32'h0;
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_rdadr = 5'd1;
        bus.lsu_valid = 1'b1; bus.lsu_rdadr = 5'd2;
        for (int i = 0; i < 3; i++) begin
            bus.alu_rd = $urandom;
            bus.lsu_rd = $urandom;
            #1;
            want_alu = (i != 1);
            n_cmp++; if (bus.alu_ready !== want_alu || bus.lsu_ready !== !want_alu) begin n_err++;
                $display("FAIL arb_grant%0d: got alu=%0b lsu=%0b want alu=%0b lsu=%0b", i, bus.alu_ready, bus.lsu_ready, want_alu, !want_alu); end
            if (want_alu) x1 = bus.alu_rd; else x2 = bus.lsu_rd;
            tick();
        end
        idle();
        tick();
        n_cmp++; if (tb_regs[1] !== x1) begin n_err++; $display("FAIL arb_regs_x1: got %h want %h", tb_regs[1], x1); end
        n_cmp++; if (tb_regs[2] !== x2) begin n_err++; $display("FAIL arb_regs_x2: got %h want %h", tb_regs[2], x2); end
    endtask

    task automatic test_x0();
        bus.lsu_valid = 1'b1; bus.lsu_rdadr = 5'd0; bus.lsu_rd = 32'hFFFFFFFF;
        #1;
        n_cmp++; if (bus.lsu_ready !== 1'b1) begin n_err++; $display("FAIL x0_lsu_ready: got %0h want 1", bus.lsu_ready); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.regwrite !== 1'b0) begin n_err++; $display("FAIL x0_regwrite: got %0h want 0", bus.regwrite); end
        bus.iss_valid = 1'b1; bus.iss_rdadr = 5'd0;
        #1;
        n_cmp++; if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL x0_iss_ready1: got %0h want 1", bus.iss_ready); end
        tick();
        #1;
        n_cmp++; if (bus.iss_ready !== 1'b1 || bus.rs1_busy !== 1'b0) begin n_err++;
            $display("FAIL x0_iss_ready2: got ready=%0h busy=%0h want 1/0", bus.iss_ready, bus.rs1_busy); end
        n_cmp++; if (tb_regs[0] !== 32'h0) begin n_err++; $display("FAIL x0_regs: got %h want 0", tb_regs[0]); end
        idle();
        tick();
    endtask

    task automatic test_busy_rules();
        do_reset();
        bus.iss_valid = 1'b1; bus.iss_rdadr = 5'd7;
        #1;
        n_cmp++; if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL busy_first_issue: got %0h want 1", bus.iss_ready); end
        tick();
        #1;
        n_cmp++; if (bus.iss_ready !== 1'b0) begin n_err++; $display("FAIL busy_reissue: got %0h want 0", bus.iss_ready); end
        tick();
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rdadr = 5'd7; bus.alu_rd = 32'h00000777;
        tick();
        bus.alu_valid = 1'b0; bus.rs1adr = 5'd7;
        tick();
        #1;
        n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_err++; $display("FAIL busy_cleared: got %0h want 0", bus.rs1_busy); end
        bus.alu_valid = 1'b1; bus.alu_rd = 32'h00007777;
        tick();
        bus.alu_valid = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_rdadr = 5'd7;
        #1;
        n_cmp++; if (bus.iss_ready !== 1'b1 || bus.regwrite !== 1'b1) begin n_err++;
            $display("FAIL busy_same_edge_setup: got ready=%0h regwrite=%0h want 1/1", bus.iss_ready, bus.regwrite); end
        tick();
        bus.iss_valid = 1'b0;
        #1;
        n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_err++; $display("FAIL busy_set_wins: got %0h want 1", bus.rs1_busy); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] old_x3;
        do_reset();
        old_x3 = m_regs[3];
        bus.iss_valid = 1'b1; bus.iss_rdadr = 5'd3;
        tick();
        bus.iss_valid = 1'b0; bus.rs1adr = 5'd3;
        bus.alu_valid = 1'b1; bus.alu_rdadr = 5'd3; bus.alu_rd = 32'hDEADBEEF;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_alu_ready: got %0h want 1", bus.alu_ready); end
        tick();
        reset = 1'b0;
        idle();
        bus.rs1adr = 5'd3;
        #1;
        n_cmp++; if (bus.regwrite !== 1'b0) begin n_err++; $display("FAIL rstmid_regwrite: got %0h want 0", bus.regwrite); end
        n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %0h want 0", bus.rs1_busy); end
        tick();
        tick();
        n_cmp++; if (tb_regs[3] !== old_x3) begin n_err++; $display("FAIL rstmid_regs_x3: got %h want %h", tb_regs[3], old_x3); end
    endtask

    task automatic test_bypass();
        do_reset();
        bus.iss_valid = 1'b1; bus.iss_rdadr = 5'd4;
        tick();
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rdadr = 5'd4; bus.alu_rd = 32'h00110011;
        tick();
        idle();
        bus.rs1adr = 5'd4; bus.rs2adr = 5'd9;
        #1;
`ifdef WB_BYPASS_EN
        n_cmp++; if (bus.rs1_fwd_valid !== 1'b1 || bus.rs1_fwd_data !== 32'h00110011) begin n_err++;
            $display("FAIL bypass_fwd: got %0h/%h want 1/00110011", bus.rs1_fwd_valid, bus.rs1_fwd_data); end
        n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_err++; $display("FAIL bypass_busy: got %0h want 0", bus.rs1_busy); end
`else
        n_cmp++; if (bus.rs1_fwd_valid !== 1'b0 || bus.rs1_fwd_data !== 32'h0) begin n_err++;
            $display("FAIL bypass_fwd: got %0h/%h want 0/0", bus.rs1_fwd_valid, bus.rs1_fwd_data); end
        n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_err++; $display("FAIL bypass_busy: got %0h want 1", bus.rs1_busy); end
`endif
        n_cmp++; if (bus.rs2_fwd_valid !== 1'b0 || bus.rs2_fwd_data !== 32'h0) begin n_err++;
            $display("FAIL bypass_rs2_miss: got %0h/%h want 0/0", bus.rs2_fwd_valid, bus.rs2_fwd_data); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset         = ($urandom_range(0, 63) == 0);
            bus.alu_valid = 1'($urandom_range(0, 1));
            bus.alu_rdadr = 5'($urandom_range(0, 7));
            bus.alu_rd    = $urandom;
            bus.lsu_valid = 1'($urandom_range(0, 1));
            bus.lsu_rdadr = 5'($urandom_range(0, 7));
            bus.lsu_rd    = $urandom;
            bus.iss_valid = 1'($urandom_range(0, 1));
            bus.iss_rdadr = 5'($urandom_range(0, 7));
            bus.rs1adr    = 5'($urandom_range(0, 7));
            bus.rs2adr    = 5'($urandom_range(0, 7));
            #1;
            model_eval();
            n_cmp++; if (bus.alu_ready !== e_alu_ready || bus.lsu_ready !== e_lsu_ready) begin n_err++;
                $display("FAIL rnd_ready c%0d: got alu=%0b lsu=%0b want alu=%0b lsu=%0b", c, bus.alu_ready, bus.lsu_ready, e_alu_ready, e_lsu_ready); end
            n_cmp++; if (bus.iss_ready !== e_iss_ready) begin n_err++;
                $display("FAIL rnd_iss_ready c%0d: got %0b want %0b", c, bus.iss_ready, e_iss_ready); end
            n_cmp++; if (bus.rs1_busy !== e_rs1_busy || bus.rs2_busy !== e_rs2_busy) begin n_err++;
                $display("FAIL rnd_busy c%0d: got %0b%0b want %0b%0b", c, bus.rs1_busy, bus.rs2_busy, e_rs1_busy, e_rs2_busy); end
            n_cmp++; if (bus.regwrite !== m_pend || bus.rdadr !== m_out_adr || bus.rd !== m_out_data) begin n_err++;
                $display("FAIL rnd_wport c%0d: got %0b/%0h/%h want %0b/%0h/%h", c, bus.regwrite, bus.rdadr, bus.rd, m_pend, m_out_adr, m_out_data); end
            n_cmp++; if (bus.rs1_fwd_valid !== e_f1v || bus.rs1_fwd_data !== e_f1d || bus.rs2_fwd_valid !== e_f2v || bus.rs2_fwd_data !== e_f2d) begin n_err++;
                $display("FAIL rnd_fwd c%0d: got %0b/%h %0b/%h want %0b/%h %0b/%h", c, bus.rs1_fwd_valid, bus.rs1_fwd_data,
                         bus.rs2_fwd_valid, bus.rs2_fwd_data, e_f1v, e_f1d, e_f2v, e_f2d); end
            tick();
        end
        reset = 1'b0;
        idle();
        tick();
        tick();
        for (int r = 0; r < 32; r++) begin
            n_cmp++; if (tb_regs[r] !== m_regs[r]) begin n_err++;
                $display("FAIL rnd_regs x%0d: got %h want %h", r, tb_regs[r], m_regs[r]); end
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        model_clock(1'b1);
        @(negedge clk);
        test_reset();
        test_basic();
        test_arbitration();
        test_x0();
        test_busy_rules();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
